rng_req_sched: RTL and testbench

- Controller that sequences the shared tt_um_rng core and shares its 8-bit output among NREQ requesters.
- Owns the RNG's seed/mode load, its warm-up after every reseed, and per-word stepping.
- Grants words round-robin so each random word reaches exactly one requester.
- Sits between the RNG core and the consumer blocks (display, dice, test-pattern logic).

---
 rtl/rng_req_sched.sv | 175 +++++++++++++++++
 tb/tb_rng_req_sched.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rng_req_sched.sv
// Sequencer for the shared tt_um_rng core: seeds and warms up the core, then steps it
// once per granted word and hands each word to exactly one requester, round-robin.
//
// state   | meaning
// --------+-------------------------------------------------------------
// SEED    | rng_load pulse with latched seed/mode
// WARMUP  | WARMUP_CYC discarded steps after a load
// ARB     | ready; pick next requester round-robin
// STEP    | advance the core once for the granted word
// WAIT    | RNG_LAT cycles for the core output, captured on the last one
// DELIVER | rnd_valid to the grantee, advance rr pointer
module rng_req_sched #(
    parameter int         NREQ       = 4,
    parameter int         WARMUP_CYC = 8,
    parameter int         RNG_LAT    = 1,
    parameter logic [3:0] DEF_SEED   = 4'h1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      cfg_seed,
    input  logic [1:0]      cfg_mode,
    input  logic            cfg_reseed,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic            rnd_valid,
    output logic [7:0]      rnd_data,
    output logic            ready,
    output logic [3:0]      rng_seed,
    output logic [1:0]      rng_mode,
    output logic            rng_load,
    output logic            rng_step,
    input  logic [7:0]      rng_data
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_SEED,
        S_WARMUP,
        S_ARB,
        S_STEP,
        S_WAIT,
        S_DELIVER
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      seed_q, seed_d;
    logic [1:0]      mode_q, mode_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      data_q, data_d;
    logic            pend_q, pend_d;
    logic            found;
    logic [IW-1:0]   pick;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return IW'(s);
    endfunction

    always_comb begin
        found = 1'b0;
        pick  = rr_q;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[wrap_add(rr_q, i)]) begin
                found = 1'b1;
                pick  = wrap_add(rr_q, i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        seed_d    = seed_q;
        mode_d    = mode_q;
        rr_d      = rr_q;
        idx_d     = idx_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        pend_d    = pend_q;
        rng_load  = 1'b0;
        rng_step  = 1'b0;
        rnd_valid = 1'b0;

        // Seed 0 locks the LFSR up, so it is never allowed into the register.
        if (cfg_reseed) begin
            seed_d = (cfg_seed == 4'h0) ? 4'h1 : cfg_seed;
            mode_d = cfg_mode;
        end

        case (state_q)
            S_SEED: begin
                rng_load = !rst;
                pend_d   = 1'b0;
                cnt_d    = 8'(WARMUP_CYC - 1);
                if (!cfg_reseed) state_d = S_WARMUP;
            end
            S_WARMUP: begin
                rng_step = 1'b1;
                if (cfg_reseed)          state_d = S_SEED;
                else if (cnt_q == 8'd0)  state_d = S_ARB;
                else                     cnt_d   = cnt_q - 8'd1;
            end
            S_ARB: begin
                if (cfg_reseed) begin
                    state_d = S_SEED;
                end else if (found) begin
                    idx_d       = pick;
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    state_d     = S_STEP;
                end
            end
            S_STEP: begin
                rng_step = 1'b1;
                cnt_d    = 8'(RNG_LAT - 1);
                state_d  = S_WAIT;
                if (cfg_reseed) pend_d = 1'b1;
            end
            S_WAIT: begin
                if (cfg_reseed) pend_d = 1'b1;
                if (cnt_q == 8'd0) begin
                    data_d  = rng_data;
                    state_d = S_DELIVER;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DELIVER: begin
                rnd_valid = 1'b1;
                gnt_d     = '0;
                rr_d      = wrap_add(idx_q, 1);
                state_d   = (pend_q || cfg_reseed) ? S_SEED : S_ARB;
            end
            default: state_d = S_SEED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_SEED;
            seed_q  <= DEF_SEED;
            mode_q  <= 2'b00;
            rr_q    <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            mode_q  <= mode_d;
            rr_q    <= rr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            pend_q  <= pend_d;
        end
    end

    assign gnt      = gnt_q;
    assign rnd_data = data_q;
    assign rng_seed = seed_q;
    assign rng_mode = mode_q;
    assign ready    = (state_q == S_ARB) || (state_q == S_STEP) ||
                      (state_q == S_WAIT) || (state_q == S_DELIVER);

endmodule

// File: tb/tb_rng_req_sched.sv
// Bench for rng_req_sched: directed boot/reseed/reset sequences, a grant table and
// randomized requesters checked against a delivery scoreboard.
module tb_rng_req_sched;

    localparam int         NREQ       = 4;
    localparam int         WARMUP_CYC = 8;
    localparam int         RNG_LAT    = 1;
    localparam logic [3:0] DEF_SEED   = 4'h1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      cfg_seed = 4'h0;
    logic [1:0]      cfg_mode = 2'b00;
    logic            cfg_reseed = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] gnt;
    logic            rnd_valid;
    logic [7:0]      rnd_data;
    logic            ready;
    logic [3:0]      rng_seed;
    logic [1:0]      rng_mode;
    logic            rng_load;
    logic            rng_step;
    logic [7:0]      rng_data = 8'h00;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ndel = 0;

    rng_req_sched #(
        .NREQ(NREQ), .WARMUP_CYC(WARMUP_CYC), .RNG_LAT(RNG_LAT), .DEF_SEED(DEF_SEED)
    ) dut (
        .clk(clk), .rst(rst), .cfg_seed(cfg_seed), .cfg_mode(cfg_mode),
        .cfg_reseed(cfg_reseed), .req(req), .gnt(gnt), .rnd_valid(rnd_valid),
        .rnd_data(rnd_data), .ready(ready), .rng_seed(rng_seed), .rng_mode(rng_mode),
        .rng_load(rng_load), .rng_step(rng_step), .rng_data(rng_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in RNG core: one-cycle latency, consecutive words differ by 8'h5B.
    always @(posedge clk) begin
        if (rng_load)      rng_data <= {rng_seed, 2'b00, rng_mode};
        else if (rng_step) rng_data <= rng_data + 8'h5B;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic logic [NREQ-1:0] exp_grant(input logic [NREQ-1:0] r, input int p);
        logic [NREQ-1:0] g;
        int k;
        g = '0;
        for (int o = 0; o < NREQ; o++) begin
            k = (p + o) % NREQ;
            if (r[k] && g == '0) g[k] = 1'b1;
        end
        return g;
    endfunction

    function automatic int onehot_idx(input logic [NREQ-1:0] g);
        int r;
        r = 0;
        for (int i = 0; i < NREQ; i++) if (g[i]) r = i;
        return r;
    endfunction

    // Reference model: every non-warm-up step owes one delivery to the requester
    // chosen from the previous cycle's requests, due 1+RNG_LAT cycles later.
    typedef struct {
        int              due;
        logic [NREQ-1:0] g;
        logic [7:0]      d;
    } exp_t;

    exp_t            q[$];
    logic            prev_rst = 1'b1;
    logic [NREQ-1:0] prev_req = '0;
    logic            word_step_prev = 1'b0;
    logic            loaded = 1'b0;
    int              steps = 0;
    int              reseed_age = -1;
    int              m_rr = 0;
    logic [3:0]      exp_seed = DEF_SEED;
    logic [1:0]      exp_mode = 2'b00;

    always @(negedge clk) begin
        logic [NREQ-1:0] eg;
        if (prev_rst) begin
            q.delete();
            word_step_prev = 1'b0;
            loaded = 1'b0;
            steps = 0;
            reseed_age = -1;
            exp_seed = DEF_SEED;
            exp_mode = 2'b00;
            m_rr = 0;
            chk("rst_gnt", gnt, 0);
            chk("rst_valid", rnd_valid, 0);
            chk("rst_ready", ready, 0);
            chk("rst_step", rng_step, 0);
            chk("rst_data", rnd_data, 0);
            chk("rst_seed", rng_seed, DEF_SEED);
            chk("rst_mode", rng_mode, 0);
            chk("rst_load", rng_load, !rst);
        end
        if (word_step_prev && q.size() > 0) q[q.size()-1].d = rng_data;
        word_step_prev = 1'b0;
        chk("load_step_excl", rng_load & rng_step, 0);
        if (rng_load) begin
            chk("load_seed", rng_seed, exp_seed);
            chk("load_mode", rng_mode, exp_mode);
            loaded = 1'b1;
            steps = 0;
            reseed_age = -1;
        end
        chk("ready", ready, loaded && steps >= WARMUP_CYC && !rng_load);
        if (rng_step) begin
            if (steps >= WARMUP_CYC) begin
                eg = exp_grant(prev_req, m_rr);
                chk("step_while_reseed_pending", reseed_age >= 0, 0);
                chk("step_has_req", eg != '0, 1);
                q.push_back('{cyc + 1 + RNG_LAT, eg, 8'h00});
                word_step_prev = 1'b1;
            end
            steps++;
        end
        chk("gnt", gnt, (q.size() > 0) ? q[0].g : '0);
        chk("rnd_valid", rnd_valid, q.size() > 0 && q[0].due == cyc);
        if (q.size() > 0 && q[0].due <= cyc) begin
            if (rnd_valid) begin
                chk("rnd_data", rnd_data, q[0].d);
                ndel++;
            end
            m_rr = (onehot_idx(q[0].g) + 1) % NREQ;
            void'(q.pop_front());
        end
        if (reseed_age >= 0) begin
            reseed_age++;
            if (reseed_age > 4 + RNG_LAT) begin
                chk("reseed_load_timeout", reseed_age, 4 + RNG_LAT);
                reseed_age = -1;
            end
        end
        if (cfg_reseed) begin
            exp_seed = (cfg_seed == 4'h0) ? 4'h1 : cfg_seed;
            exp_mode = cfg_mode;
            if (reseed_age < 0) reseed_age = 0;
        end
        prev_req = req;
        prev_rst = rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_arb();
        int n;
        n = 0;
        @(negedge clk);
        while (!(ready && gnt == '0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wait_arb_timeout", ready && gnt == '0, 1);
    endtask

    task automatic wait_valid(input string name, output int at);
        int n;
        n = 0;
        @(negedge clk);
        while (!rnd_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(name, rnd_valid, 1);
        at = cyc;
    endtask

    typedef struct {
        logic [NREQ-1:0] r;
        logic [NREQ-1:0] g;
    } vec_t;

    initial begin
        vec_t            tbl[10];
        int              t0, at;
        int              vt[5];
        logic [NREQ-1:0] vg[5];
        logic [7:0]      vd[5];
        logic [7:0]      w, nx;
        logic [NREQ-1:0] dv;

        // Grant table, starting with the rr pointer at 1.
        tbl[0] = '{4'b0001, 4'b0001};
        tbl[1] = '{4'b1001, 4'b1000};
        tbl[2] = '{4'b0110, 4'b0010};
        tbl[3] = '{4'b0110, 4'b0100};
        tbl[4] = '{4'b0011, 4'b0001};
        tbl[5] = '{4'b1110, 4'b0010};
        tbl[6] = '{4'b1000, 4'b1000};
        tbl[7] = '{4'b0101, 4'b0001};
        tbl[8] = '{4'b0101, 4'b0100};
        tbl[9] = '{4'b1010, 4'b1000};

        // Boot: auto-seed, 8 warm-up steps, then ready.
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("boot_load", rng_load, 1);
        chk("boot_seed", rng_seed, 4'h1);
        chk("boot_mode", rng_mode, 0);
        chk("boot_ready_low", ready, 0);
        for (int i = 0; i < WARMUP_CYC; i++) begin
            @(negedge clk);
            chk("boot_warm_step", rng_step, 1);
            chk("boot_warm_ready", ready, 0);
        end
        @(negedge clk);
        chk("boot_ready", ready, 1);
        chk("boot_idle_step", rng_step, 0);

        // All four requesting: order 0,1,2,3,0, one word every 4 cycles.
        tick();
        t0 = cyc;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_valid("all_valid", at);
            vt[k] = at;
            vg[k] = gnt;
            vd[k] = rnd_data;
        end
        tick();
        req = '0;
        for (int k = 0; k < 5; k++) begin
            chk("all_gnt_order", vg[k], 4'b0001 << (k % 4));
            chk("all_valid_time", vt[k], t0 + 3 + 4 * k);
        end
        for (int k = 0; k < 4; k++) begin
            nx = vd[k] + 8'h5B;
            chk("all_consecutive_words", vd[k+1], nx);
        end

        // Single requester latency.
        wait_arb();
        tick();
        req = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        chk("single_gnt", gnt, 4'b0001);
        chk("single_step", rng_step, 1);
        @(negedge clk);
        w = rng_data;
        @(negedge clk);
        chk("single_valid", rnd_valid, 1);
        chk("single_data", rnd_data, w);
        chk("single_gnt_hold", gnt, 4'b0001);
        tick();
        req = '0;

        // Grant table.
        for (int v = 0; v < 10; v++) begin
            wait_arb();
            tick();
            req = tbl[v].r;
            wait_valid("tbl_valid", at);
            chk("tbl_gnt", gnt, tbl[v].g);
            tick();
            req = '0;
        end

        // Reseed with seed 0 during WAIT, then a second reseed in warm-up cycle 4.
        wait_arb();
        tick();
        req = 4'b0001;
        cfg_seed = 4'h0;
        cfg_mode = 2'b10;
        tick();
        tick();
        cfg_reseed = 1'b1;
        tick();
        cfg_reseed = 1'b0;
        @(negedge clk);
        chk("reseed_word_valid", rnd_valid, 1);
        chk("reseed_word_gnt", gnt, 4'b0001);
        tick();
        req = '0;
        @(negedge clk);
        chk("reseed_load", rng_load, 1);
        chk("reseed_seed_fix", rng_seed, 4'h1);
        chk("reseed_mode", rng_mode, 2'b10);
        chk("reseed_ready_low", ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reseed_warm_step", rng_step, 1);
            chk("reseed_warm_ready", ready, 0);
        end
        tick();
        cfg_seed = 4'h9;
        cfg_reseed = 1'b1;
        @(negedge clk);
        chk("reseed2_warm4_step", rng_step, 1);
        tick();
        cfg_reseed = 1'b0;
        @(negedge clk);
        chk("reseed2_load", rng_load, 1);
        chk("reseed2_seed", rng_seed, 4'h9);
        chk("reseed2_mode", rng_mode, 2'b10);
        for (int i = 0; i < WARMUP_CYC; i++) begin
            @(negedge clk);
            chk("reseed2_warm_step", rng_step, 1);
            chk("reseed2_warm_ready", ready, 0);
        end
        @(negedge clk);
        chk("reseed2_ready", ready, 1);

        // Randomized requesters with occasional reseeds.
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            dv = rnd_valid ? gnt : '0;
            tick();
            cfg_reseed = ($urandom_range(0, 79) == 0);
            cfg_seed = 4'($urandom);
            cfg_mode = 2'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i])     req[i] = ($urandom_range(0, 3) == 0);
                else if (dv[i])  req[i] = ($urandom_range(0, 1) == 0);
            end
        end
        tick();
        cfg_reseed = 1'b0;
        req = '0;
        repeat (30) tick();
        chk("random_delivered", ndel > 100, 1);

        // Reset during WAIT: word aborted, auto-seed restarts.
        wait_arb();
        tick();
        req = 4'b0100;
        tick();
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("rstw_valid", rnd_valid, 0);
        chk("rstw_gnt", gnt, 0);
        chk("rstw_ready", ready, 0);
        chk("rstw_load", rng_load, 0);
        tick();
        rst = 1'b0;
        req = '0;
        @(negedge clk);
        chk("rstw_load_after", rng_load, 1);
        chk("rstw_seed", rng_seed, DEF_SEED);
        chk("rstw_mode", rng_mode, 0);
        for (int i = 0; i < WARMUP_CYC; i++) begin
            @(negedge clk);
            chk("rstw_warm_step", rng_step, 1);
            chk("rstw_no_valid", rnd_valid, 0);
        end
        @(negedge clk);
        chk("rstw_ready", ready, 1);
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
